// File: rtl/instruction_fetch_buffer.sv
// Prefetch stage: owns the fetch PC, issues word requests to program memory and
// queues returned instructions with their PC+4 in a first-word-fall-through FIFO.
module instruction_fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     mem_req_o,
  output logic [31:0]              mem_addr_o,
  input  logic                     mem_ack_i,
  input  logic [31:0]              mem_data_i,
  input  logic                     redirect_i,
  input  logic [31:0]              redirect_pc_i,
  input  logic                     stall_i,
  output logic [31:0]              instr_o,
  output logic [31:0]              pc_4_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   occupancy_o
);

  // state | meaning
  // IDLE  | no request outstanding, waiting for FIFO credit
  // REQ   | request outstanding, its data will be queued
  // DRAIN | request outstanding whose data is dropped after a redirect
  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   next_pc;
  logic [31:0]   addr_4;
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc4_mem   [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [AW:0]   next_count;
  logic          discard;
  logic          xfer;
  logic          push;
  logic          pop;
  logic          credit;

  assign xfer    = mem_req_o & mem_ack_i;
  assign addr_4  = mem_addr_o + 32'd4;
  assign push    = xfer & ~discard & ~redirect_i;
  assign valid_o = (count != '0);
  assign pop     = valid_o & ~stall_i & ~redirect_i;

  always_comb begin
    next_count = count;
    if (redirect_i)
      next_count = '0;
    else if (push && !pop)
      next_count = count + 1'b1;
    else if (pop && !push)
      next_count = count - 1'b1;
  end

  // Credit looks at the post-edge occupancy so a zero-wait memory streams one word per cycle.
  assign credit = (next_count < DEPTH_C);

  always_comb begin
    next_pc = fetch_pc;
    if (redirect_i)
      next_pc = redirect_pc_i & 32'hFFFF_FFFC;
    else if (push)
      next_pc = addr_4;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      mem_req_o  <= 1'b0;
      mem_addr_o <= 32'h0;
      discard    <= 1'b0;
      fetch_pc   <= RESET_PC;
    end else begin
      fetch_pc <= next_pc;
      case (state)
        IDLE: begin
          if (credit) begin
            state      <= REQ;
            mem_req_o  <= 1'b1;
            mem_addr_o <= next_pc;
          end
        end
        REQ: begin
          if (mem_ack_i) begin
            if (credit) begin
              mem_addr_o <= next_pc;
            end else begin
              state     <= IDLE;
              mem_req_o <= 1'b0;
            end
          end else if (redirect_i) begin
            state   <= DRAIN;
            discard <= 1'b1;
          end
        end
        DRAIN: begin
          if (mem_ack_i) begin
            discard <= 1'b0;
            if (credit) begin
              state      <= REQ;
              mem_addr_o <= next_pc;
            end else begin
              state     <= IDLE;
              mem_req_o <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          mem_req_o <= 1'b0;
          discard   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= next_count;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= mem_data_i;
      pc4_mem[wr_ptr]   <= addr_4;
    end
  end

  assign instr_o     = valid_o ? instr_mem[rd_ptr] : 32'h0;
  assign pc_4_o      = valid_o ? pc4_mem[rd_ptr]   : 32'h0;
  assign occupancy_o = count;

endmodule

// File: doc/instruction_fetch_buffer.md
Name: instruction_fetch_buffer

Overview:
Prefetch stage between the program memory and the IF/ID pipeline register. It owns the fetch PC and issues word requests to a variable-latency program memory. Returned instructions are queued with their PC+4 in a DEPTH-entry first-word-fall-through FIFO. The FIFO decouples fetch from ID stalls and is flushed by taken branch, jump and jr redirects from the MEM stage.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2.
RESET_PC, 32'h0040_0000, first fetch address after reset.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
mem_req_o  output  1  request to program memory; held until acknowledged.
mem_addr_o  output  32  word address of the request; stable while mem_req_o=1.
mem_ack_i  input  1  memory has returned mem_data_i for the current request this cycle.
mem_data_i  input  32  instruction word; valid only when mem_ack_i=1.
redirect_i  input  1  one-cycle pulse: taken beq/bne, j/jal or jr resolved in MEM.
redirect_pc_i  input  32  new fetch address; bits [1:0] are ignored and treated as 00.
stall_i  input  1  ID is not accepting an instruction this cycle.
instr_o  output  32  head instruction; 32'h0000_0000 (NOP) when valid_o=0.
pc_4_o  output  32  head instruction address + 4; 0 when valid_o=0.
valid_o  output  1  FIFO is non-empty.
occupancy_o  output  $clog2(DEPTH)+1  number of queued entries.

Behaviour:
- Reset (asynchronous): fetch_pc=RESET_PC, FIFO empty, occupancy_o=0, valid_o=0, instr_o=0, pc_4_o=0, mem_req_o=0, discard flag=0. mem_req_o first rises in the cycle after reset deasserts.
- Reset mid-transaction abandons any outstanding request. A mem_ack_i arriving after reset deasserts while mem_req_o=0 is ignored.
- Memory handshake: at most one outstanding request. Once mem_req_o=1, it and mem_addr_o hold until the cycle with mem_ack_i=1. The transfer completes in that cycle. mem_ack_i while mem_req_o=0 is ignored.
- Issue credit: mem_req_o is registered. It is asserted in the next cycle iff no request remains outstanding and next_occupancy + 1 <= DEPTH. next_occupancy includes this cycle's push and pop.
- Credit rule consequences: the FIFO can never overflow, and a zero-wait memory sustains one instruction per cycle.
- Push: on a completed transfer with discard=0 and redirect_i=0, the FIFO writes {mem_data_i, mem_addr_o+4} and fetch_pc becomes mem_addr_o+4.
- Address arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- Pop: occurs when valid_o=1 and stall_i=0. instr_o and pc_4_o show the head combinationally from FIFO storage.
- Simultaneous push and pop: occupancy is unchanged, and the read and write pointers both advance with wrap at DEPTH.
- Latency: with a request in cycle N and ack in cycle N, valid_o=1 in cycle N+1.
- Redirect has priority over push, pop and issue.
  - Redirect clears the FIFO in the same edge (occupancy 0) and sets fetch_pc = {redirect_pc_i[31:2], 2'b00}.
  - If a request is outstanding and not acknowledged in the redirect cycle, discard is set. The request stays asserted at its old address. Its later ack is dropped and clears discard.
  - If ack and redirect coincide, that data is dropped.
  - The first request to the redirect PC issues the cycle after the old request completes, or the cycle after the redirect if none was outstanding.
- A second redirect while discard=1 only updates fetch_pc.
- stall_i while empty has no effect. A redirect while stalled still flushes.
- State machine, mem side:
  - IDLE: go to REQ when credit is available.
  - REQ: on ack, go to REQ if credit is available, else IDLE.
  - REQ with a redirect and no ack: go to DRAIN, with discard set.
  - DRAIN: on ack, go to REQ at fetch_pc.

Test Plan:
1. Reset release, zero-wait memory (ack = req), stall_i=0 -> mem_addr_o steps 0x00400000, 0x00400004, … one per cycle. pc_4_o = 0x00400004, 0x00400008, …; valid_o=1 from the 2nd cycle after release onward.
2. Hold stall_i=1 with zero-wait memory -> occupancy_o reaches 4 and mem_req_o drops. Release stall for one cycle -> exactly one pop, and the next request goes out at 0x00400010.
3. Memory with 3 wait states, no stall -> each instruction appears 4 cycles apart. mem_addr_o is stable while waiting, and valid_o pulses with the correct instr/pc_4 pairing.
4. Occupancy 3 and redirect_i with redirect_pc_i=0x00400103 -> occupancy_o=0 and valid_o=0 next cycle. The next request is at 0x00400100, and the first instr_o has pc_4_o = 0x00400104.
5. Outstanding request at 0x00400008 with 2 wait states, redirect to 0x00400040 in wait cycle 1 -> the ack data for 0x00400008 never appears. The next request is at 0x00400040.
6. Assert reset asynchronously mid-wait-state with occupancy 2 -> all outputs are zero immediately. A stray ack in the first post-reset cycle is ignored, and fetch restarts at 0x00400000.
